// File: rtl/mem_arbiter.sv
// Two-port to one-cache request arbiter with a single outstanding transaction.
// Round-robin or fixed-priority tie-break; every output comes straight from a flop.
module mem_arbiter #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        P0_ADDR_VALID,
  input  logic [31:0] P0_ADDR,
  input  logic        P0_DATA_VALID,
  input  logic [31:0] P0_DATA,
  output logic        P0_READY,
  output logic        P0_RESP_VALID,
  output logic [31:0] P0_RESP_DATA,
  input  logic        P0_RESP_READY,
  input  logic        P1_ADDR_VALID,
  input  logic [31:0] P1_ADDR,
  input  logic        P1_DATA_VALID,
  input  logic [31:0] P1_DATA,
  output logic        P1_READY,
  output logic        P1_RESP_VALID,
  output logic [31:0] P1_RESP_DATA,
  input  logic        P1_RESP_READY,
  output logic        M_ADDR_VALID,
  output logic [31:0] M_ADDR,
  output logic        M_DATA_VALID,
  output logic [31:0] M_DATA,
  input  logic        M_READY,
  input  logic        M_SEND_VALID,
  input  logic [31:0] M_SEND_DATA,
  output logic        M_SEND_READY,
  output logic [1:0]  GRANT,
  output logic        BUSY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]       state;
  logic             last;
  logic [1:0]       grant_q, ready_q, rvld_q;
  logic [1:0][31:0] rdata_q;
  logic             busy_q, m_av_q, m_dv_q, m_sr_q;
  logic [31:0]      m_addr_q, m_data_q;

  logic [1:0]  req;
  logic        pick, own, sel_dv, sel_rr;
  logic [31:0] sel_addr, sel_data;

  assign req = {P1_ADDR_VALID, P0_ADDR_VALID};
  // Owner index is the high bit of the one-hot grant; only meaningful while busy.
  assign own = grant_q[1];

  always_comb begin
    pick = 1'b0;
    if (req == 2'b10)      pick = 1'b1;
    else if (req == 2'b11) pick = FIXED_PRI ? 1'b0 : ~last;
  end

  always_comb begin
    sel_addr = own ? P1_ADDR       : P0_ADDR;
    sel_data = own ? P1_DATA       : P0_DATA;
    sel_dv   = own ? P1_DATA_VALID : P0_DATA_VALID;
    sel_rr   = own ? P1_RESP_READY : P0_RESP_READY;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      grant_q  <= 2'b00;
      ready_q  <= 2'b00;
      rvld_q   <= 2'b00;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      m_av_q   <= 1'b0;
      m_dv_q   <= 1'b0;
      m_sr_q   <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req) begin
          grant_q <= pick ? 2'b10 : 2'b01;
          ready_q <= pick ? 2'b10 : 2'b01;
          busy_q  <= 1'b1;
          state   <= S_GRANT;
        end
        // READY is high this cycle, so the owner's payload is valid to capture.
        S_GRANT: begin
          ready_q  <= 2'b00;
          m_addr_q <= sel_addr;
          m_data_q <= sel_data;
          m_dv_q   <= sel_dv;
          m_av_q   <= 1'b1;
          state    <= S_ISSUE;
        end
        S_ISSUE: if (M_READY) begin
          m_av_q <= 1'b0;
          m_sr_q <= 1'b1;
          state  <= S_WAIT;
        end
        S_WAIT: if (M_SEND_VALID) begin
          rdata_q[own] <= M_SEND_DATA;
          m_sr_q       <= 1'b0;
          rvld_q       <= grant_q;
          state        <= S_RESP;
        end
        S_RESP: if (sel_rr) begin
          rvld_q  <= 2'b00;
          last    <= own;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign P0_READY      = ready_q[0];
  assign P1_READY      = ready_q[1];
  assign P0_RESP_VALID = rvld_q[0];
  assign P1_RESP_VALID = rvld_q[1];
  assign P0_RESP_DATA  = rdata_q[0];
  assign P1_RESP_DATA  = rdata_q[1];
  assign M_ADDR_VALID  = m_av_q;
  assign M_ADDR        = m_addr_q;
  assign M_DATA_VALID  = m_dv_q;
  assign M_DATA        = m_data_q;
  assign M_SEND_READY  = m_sr_q;
  assign GRANT         = grant_q;
  assign BUSY          = busy_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRI, default 0; 0 = round-robin, 1 = port 0 always wins ties.
REQ-002 SHALL have ports:
- CLK  input  1  clock; all logic on posedge.
- RST_N  input  1  synchronous active-low reset.
REQ-003 SHALL have, for each requester n in {0,1}:
- Pn_ADDR_VALID  input  1  request valid.
- Pn_ADDR  input  32  address.
- Pn_DATA_VALID  input  1  write flag (1 = write, 0 = read).
- Pn_DATA  input  32  write data.
- Pn_READY  output  1  request accepted.
- Pn_RESP_VALID  output  1  response valid.
- Pn_RESP_DATA  output  32  read data or echoed write data.
- Pn_RESP_READY  input  1  response consumed.
REQ-004 SHALL have the memory-side ports:
- M_ADDR_VALID  output  1  request to the cache.
- M_ADDR  output  32  address.
- M_DATA_VALID  output  1  write flag.
- M_DATA  output  32  write data.
- M_READY  input  1  cache accepts the request.
- M_SEND_VALID  input  1  cache response valid.
- M_SEND_DATA  input  32  cache response data.
- M_SEND_READY  output  1  response accepted.
REQ-005 SHALL have the status ports:
- GRANT  output  2  one-hot owner; 00 when idle.
- BUSY  output  1  high in any state except S_IDLE.

Function
REQ-006 SHALL register every output.
REQ-007 SHALL implement the states S_IDLE, S_GRANT, S_ISSUE, S_WAIT and S_RESP.
REQ-008 In S_IDLE, when any Pn_ADDR_VALID=1, SHALL pick a winner, set GRANT, and go to S_GRANT next cycle.
REQ-009 The winner SHALL be the only requester when just one is valid.
REQ-010 When both are valid, the winner SHALL be:
- port 0 if FIXED_PRI=1;
- otherwise the port not recorded in LAST, a 1-bit last-served pointer.
REQ-011 In S_GRANT, Pn_READY SHALL be 1 for the winner for exactly one cycle.
REQ-012 In that S_GRANT cycle the block SHALL latch Pn_ADDR, Pn_DATA_VALID and Pn_DATA into M_ADDR, M_DATA_VALID and M_DATA, then go to S_ISSUE.
REQ-013 Requesters SHALL hold their payload stable until Pn_READY=1.
REQ-014 The loser's Pn_READY SHALL stay 0, and its request SHALL remain pending.
REQ-015 In S_ISSUE, M_ADDR_VALID SHALL be 1 and held until the cycle M_ADDR_VALID && M_READY.
REQ-016 In the cycle after that handshake, M_ADDR_VALID SHALL be 0 and the state SHALL be S_WAIT.
REQ-017 M_ADDR, M_DATA and M_DATA_VALID SHALL stay stable from S_GRANT until the next S_GRANT.
REQ-018 In S_WAIT, M_SEND_READY SHALL be 1.
REQ-019 On M_SEND_VALID && M_SEND_READY, the block SHALL:
- latch M_SEND_DATA into the winner's Pn_RESP_DATA;
- drop M_SEND_READY;
- go to S_RESP.
REQ-020 M_SEND_VALID SHALL be ignored outside S_WAIT.
REQ-021 In S_RESP, the winner's Pn_RESP_VALID SHALL be 1 until Pn_RESP_VALID && Pn_RESP_READY.
REQ-022 On that response handshake the block SHALL:
- clear Pn_RESP_VALID;
- set LAST to the winner;
- clear GRANT and BUSY;
- go to S_IDLE.
REQ-023 The non-winner's Pn_RESP_VALID SHALL always be 0, and its Pn_RESP_DATA SHALL hold its last value.
REQ-024 The minimum latency from Pn_ADDR_VALID to Pn_RESP_VALID SHALL be 4 cycles, given M_READY and M_SEND_VALID both constantly 1.
REQ-025 There SHALL be exactly one transaction outstanding; new requests SHALL be sampled only in S_IDLE.
REQ-026 A request arriving in S_RESP on the same cycle as the response handshake SHALL be sampled in the following S_IDLE cycle.
REQ-027 The block SHALL insert no bubble beyond that one S_IDLE cycle.
REQ-028 Payloads and data SHALL pass through unmodified at 32 bits, with no address alignment or checking.

Reset
REQ-029 When RST_N=0 at a clock edge, the block SHALL, regardless of state (mid-transaction included):
- go to S_IDLE;
- set LAST=1, so port 0 wins the first tie;
- set GRANT=00 and BUSY=0;
- set all *_VALID and *_READY outputs to 0.
REQ-030 When RST_N=0 at a clock edge, the block SHALL also set M_ADDR, M_DATA, M_DATA_VALID and Pn_RESP_DATA to 0.
REQ-031 A transaction aborted by reset SHALL NOT be replayed.

Verification
REQ-032 Single read: P0 read addr 0x100, M_READY=1, cache returns 0xDEADBEEF one cycle after issue. The bench SHALL check:
- P0_READY pulses once;
- M_ADDR=0x100 and M_DATA_VALID=0;
- P0_RESP_DATA=0xDEADBEEF, with P0_RESP_VALID 4 cycles after the request.
REQ-033 Tie after reset: P0 and P1 both valid. The bench SHALL check:
- GRANT=01 first;
- after P0 completes, GRANT=10 serves P1;
- P1_READY stays 0 until its S_GRANT.
REQ-034 Round-robin: both ports held valid continuously for 6 transactions. The bench SHALL check the grant order 0,1,0,1,0,1.
REQ-035 With FIXED_PRI=1 and the same stimulus as REQ-034, the bench SHALL check that all 6 grants go to port 0.
REQ-036 Backpressure: P1 write, data 0x12345678. With M_READY=0 for 5 cycles, M_ADDR_VALID SHALL hold with a stable payload. With P1_RESP_READY=0 for 3 cycles, P1_RESP_VALID SHALL hold and P1_RESP_DATA SHALL equal 0x12345678.
REQ-037 Reset in S_WAIT: RST_N=0 for 1 cycle. On the next cycle the bench SHALL check:
- all VALID/READY outputs, GRANT and BUSY are 0;
- a subsequent P1-only request is granted normally;
- a stray M_SEND_VALID before re-issue is ignored.
